alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Parameter SETTLE, default 2: clk cycles from operand issue to result capture; legal range 1..15.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 rN_valid (N=0,1)  in  1  requester N presents an operation.
REQ-006 rN_ready  out  1  arbiter accepts requester N's operation this cycle.
REQ-007 rN_op  in  6  ALU op code, forwarded unchanged.
REQ-008 rN_rv1, rN_rv2  in  32  operands.
REQ-009 rN_rvalid  out  1  result for requester N is valid.
REQ-010 rN_rready  in  1  requester N consumes the result.
REQ-011 rN_rdata  out  32  result for requester N.
REQ-012 alu_op  out  6; alu_rv1, alu_rv2  out  32  drive the shared alu32.
REQ-013 alu_rvout  in  32  alu32 result.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-016 IDLE: if exactly one rN_valid is high, that requester is granted; if both are high, the requester selected by the round-robin pointer ptr is granted.
REQ-017 rN_ready SHALL be high only in IDLE and only for the granted requester; it is combinational from rN_valid and ptr.
REQ-018 The handshake is valid&ready; on it, op/rv1/rv2 and grant id are registered, cnt is loaded with SETTLE-1, and the state goes to WAIT.
REQ-019 alu_op/alu_rv1/alu_rv2 SHALL be driven only from the operand registers and held stable from the handshake edge until the exit from RESP.
REQ-020 WAIT: when cnt==0, alu_rvout is registered into the result register and the state goes to RESP; otherwise cnt decrements.
REQ-021 Latency: handshake at edge k gives result capture at edge k+SETTLE; rN_rvalid is high from that edge.
REQ-022 RESP: the granted requester's rvalid=1 and rdata=result; the other requester's rvalid=0 and rdata=0.
REQ-023 RESP with rN_rready=1 SHALL go to IDLE, set ptr to the other requester, and drop rvalid at that edge.
REQ-024 RESP with rready low SHALL hold state, rdata and ALU drive indefinitely; no new grant is made.
REQ-025 Throughput SHALL be at most one operation per SETTLE+2 cycles, because IDLE always lasts at least one cycle.
REQ-026 rN_valid dropping without a handshake SHALL have no effect; inputs change freely outside the handshake.
REQ-027 Valid asserted in WAIT or RESP is ignored until IDLE; ptr is not updated in that case.
REQ-028 The block SHALL NOT interpret op; it performs no arithmetic itself.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, ptr=0, cnt=0, and zero all operand and result registers.
REQ-030 All outputs SHALL be 0 during reset: ready, rvalid, rdata, alu_*, busy.
REQ-031 Reset asserted in WAIT or RESP SHALL discard the in-flight operation with no rvalid afterwards.
REQ-032 After rst_n deasserts, the first edge SHALL evaluate IDLE normally.

Verification
REQ-033 SETTLE=2; r0: op=6'b000000, rv1=5, rv2=3 -> r0_ready for 1 cycle, r0_rvalid 2 edges later, r0_rdata=8, r1_rvalid=0.
REQ-034 r1: op=6'b011000, rv1=5, rv2=3 -> r1_rdata=2; sra op=6'b010101, rv1=32'h80000000, rv2=4 -> rdata=32'hF8000000.
REQ-035 Both valid after reset, rready tied 1 -> grants r0, r1, r0, r1 alternating; each result goes to the correct port.
REQ-036 r0_rready low for 5 cycles in RESP -> r0_rvalid and r0_rdata stable, r1_ready=0 throughout, busy=1; r1 is granted after release.
REQ-037 rst_n pulsed low during WAIT -> all outputs 0 at once, no rvalid after release, next grant goes to r0 (ptr=0).
REQ-038 SETTLE=1 -> rvalid on the edge after the handshake, and the captured alu_rvout matches the operands.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Two-requester round-robin front end for a shared alu32. A granted
//            operation is latched, driven to the ALU for SETTLE cycles, and
//            the captured result is held on the owner's response port until
//            it is consumed. The block never interprets the op code.
// Ports    : clk, rst_n              clock, asynchronous active-low reset
//            rN_valid / rN_ready     request handshake (N = 0, 1)
//            rN_op, rN_rv1, rN_rv2   op code and operands from requester N
//            rN_rvalid / rN_rready   response handshake
//            rN_rdata                result for requester N
//            alu_op, alu_rv1/rv2     drive to the shared alu32
//            alu_rvout               alu32 result
//            busy                    high whenever not in IDLE
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int SETTLE = 2   // cycles from operand issue to capture, 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [5:0]  r0_op,
    input  logic [31:0] r0_rv1,
    input  logic [31:0] r0_rv2,
    output logic        r0_rvalid,
    input  logic        r0_rready,
    output logic [31:0] r0_rdata,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [5:0]  r1_op,
    input  logic [31:0] r1_rv1,
    input  logic [31:0] r1_rv2,
    output logic        r1_rvalid,
    input  logic        r1_rready,
    output logic [31:0] r1_rdata,
    output logic [5:0]  alu_op,
    output logic [31:0] alu_rv1,
    output logic [31:0] alu_rv2,
    input  logic [31:0] alu_rvout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t      state;
    logic        ptr;        // requester favoured on a tie
    logic        gid;        // owner of the in-flight operation
    logic [3:0]  cnt;
    logic [5:0]  op_q;
    logic [31:0] rv1_q;
    logic [31:0] rv2_q;
    logic [31:0] result;

    logic        in_idle;
    logic        hs0;
    logic        hs1;
    logic        rready_sel;

    // Ready is gated by rst_n so it reads 0 immediately while reset is held,
    // even if a requester is already presenting valid.
    assign in_idle  = (state == IDLE);
    assign r0_ready = rst_n & in_idle & r0_valid & (~r1_valid | ~ptr);
    assign r1_ready = rst_n & in_idle & r1_valid & (~r0_valid |  ptr);
    assign hs0      = r0_valid & r0_ready;
    assign hs1      = r1_valid & r1_ready;

    assign rready_sel = gid ? r1_rready : r0_rready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            gid    <= 1'b0;
            cnt    <= 4'd0;
            op_q   <= 6'd0;
            rv1_q  <= 32'd0;
            rv2_q  <= 32'd0;
            result <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs0 | hs1) begin
                        gid   <= hs1;
                        op_q  <= hs1 ? r1_op  : r0_op;
                        rv1_q <= hs1 ? r1_rv1 : r0_rv1;
                        rv2_q <= hs1 ? r1_rv2 : r0_rv2;
                        cnt   <= CNT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        result <= alu_rvout;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Only the owner's rready matters; the pointer moves to
                    // the other requester so a contended next grant alternates.
                    if (rready_sel) begin
                        ptr   <= ~gid;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The ALU sees only the operand registers, which stay constant from the
    // handshake until the response is consumed.
    assign alu_op  = op_q;
    assign alu_rv1 = rv1_q;
    assign alu_rv2 = rv2_q;

    assign r0_rvalid = (state == RESP) & ~gid;
    assign r1_rvalid = (state == RESP) &  gid;
    assign r0_rdata  = r0_rvalid ? result : 32'd0;
    assign r1_rdata  = r1_rvalid ? result : 32'd0;
    assign busy      = ~in_idle;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter. A small alu32
//            stand-in answers add, sub and sra; a second instance runs with
//            SETTLE=1.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_valid, r0_ready, r0_rvalid, r0_rready;
    logic [5:0]  r0_op;
    logic [31:0] r0_rv1, r0_rv2, r0_rdata;
    logic        r1_valid, r1_ready, r1_rvalid, r1_rready;
    logic [5:0]  r1_op;
    logic [31:0] r1_rv1, r1_rv2, r1_rdata;
    logic [5:0]  alu_op;
    logic [31:0] alu_rv1, alu_rv2, alu_rvout;
    logic        busy;

    logic        s_r0_valid, s_r0_ready, s_r0_rvalid, s_r0_rready;
    logic [5:0]  s_r0_op;
    logic [31:0] s_r0_rv1, s_r0_rv2, s_r0_rdata;
    logic        s_r1_ready, s_r1_rvalid;
    logic [31:0] s_r1_rdata;
    logic [5:0]  s_alu_op;
    logic [31:0] s_alu_rv1, s_alu_rv2, s_alu_rvout;
    logic        s_busy;

    int tests_run = 0;
    int tests_failed = 0;

    function automatic logic [31:0] alu_model(input logic [5:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            6'b000000: alu_model = a + b;
            6'b011000: alu_model = a - b;
            6'b010101: alu_model = 32'($signed(a) >>> b[4:0]);
            default:   alu_model = a ^ b;
        endcase
    endfunction

    assign alu_rvout   = alu_model(alu_op, alu_rv1, alu_rv2);
    assign s_alu_rvout = alu_model(s_alu_op, s_alu_rv1, s_alu_rv2);

    alu_arbiter #(.SETTLE(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
        .r0_rv1(r0_rv1), .r0_rv2(r0_rv2), .r0_rvalid(r0_rvalid),
        .r0_rready(r0_rready), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
        .r1_rv1(r1_rv1), .r1_rv2(r1_rv2), .r1_rvalid(r1_rvalid),
        .r1_rready(r1_rready), .r1_rdata(r1_rdata),
        .alu_op(alu_op), .alu_rv1(alu_rv1), .alu_rv2(alu_rv2),
        .alu_rvout(alu_rvout), .busy(busy)
    );

    alu_arbiter #(.SETTLE(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(s_r0_valid), .r0_ready(s_r0_ready), .r0_op(s_r0_op),
        .r0_rv1(s_r0_rv1), .r0_rv2(s_r0_rv2), .r0_rvalid(s_r0_rvalid),
        .r0_rready(s_r0_rready), .r0_rdata(s_r0_rdata),
        .r1_valid(1'b0), .r1_ready(s_r1_ready), .r1_op(6'd0),
        .r1_rv1(32'd0), .r1_rv2(32'd0), .r1_rvalid(s_r1_rvalid),
        .r1_rready(1'b0), .r1_rdata(s_r1_rdata),
        .alu_op(s_alu_op), .alu_rv1(s_alu_rv1), .alu_rv2(s_alu_rv2),
        .alu_rvout(s_alu_rvout), .busy(s_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1; s_r0_valid = 1'b1;
        tick(); tick();
        tests_run++;
        if ({r0_ready, r1_ready, s_r0_ready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 000", {r0_ready, r1_ready, s_r0_ready});
        end
        tests_run++;
        if ({busy, r0_rvalid, r1_rvalid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_busy_rvalid: got %b expected 000", {busy, r0_rvalid, r1_rvalid});
        end
        tests_run++;
        if ({r0_rdata, r1_rdata, alu_rv1, alu_rv2, alu_op} !== 134'd0) begin
            tests_failed++;
            $display("FAIL reset_data: rdata0=%h rdata1=%h rv1=%h rv2=%h op=%b expected all 0",
                     r0_rdata, r1_rdata, alu_rv1, alu_rv2, alu_op);
        end
        r0_valid = 1'b0; r1_valid = 1'b0; s_r0_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_add;
        r0_op = 6'b000000; r0_rv1 = 32'd5; r0_rv2 = 32'd3; r0_valid = 1'b1;
        #1;
        tests_run++;
        if ({r0_ready, r1_ready, busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL add_grant: ready0/ready1/busy=%b expected 100", {r0_ready, r1_ready, busy});
        end
        tick();
        r0_valid = 1'b0;
        tests_run++;
        if ({r0_ready, busy, r0_rvalid, alu_rv1} !== {3'b010, 32'd5}) begin
            tests_failed++;
            $display("FAIL add_wait: ready0=%b busy=%b rvalid0=%b alu_rv1=%0d expected 0 1 0 5",
                     r0_ready, busy, r0_rvalid, alu_rv1);
        end
        tick();
        tests_run++;
        if (r0_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_early: rvalid0=%b expected 0 one edge before capture", r0_rvalid);
        end
        tick();
        tests_run++;
        if ({r0_rvalid, r0_rdata, r1_rvalid, r1_rdata} !== {1'b1, 32'd8, 1'b0, 32'd0}) begin
            tests_failed++;
            $display("FAIL add_result: rvalid0=%b rdata0=%0d rvalid1=%b rdata1=%0d expected 1 8 0 0",
                     r0_rvalid, r0_rdata, r1_rvalid, r1_rdata);
        end
        r0_rready = 1'b1;
        tick();
        r0_rready = 1'b0;
        tests_run++;
        if ({r0_rvalid, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL add_release: rvalid0=%b busy=%b expected 0 0", r0_rvalid, busy);
        end
    endtask

    task automatic test_sub_sra;
        r1_op = 6'b011000; r1_rv1 = 32'd5; r1_rv2 = 32'd3; r1_valid = 1'b1;
        #1;
        tests_run++;
        if ({r0_ready, r1_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL sub_grant: ready0/ready1=%b expected 01", {r0_ready, r1_ready});
        end
        tick(); r1_valid = 1'b0;
        tick(); tick();
        tests_run++;
        if ({r1_rvalid, r1_rdata, r0_rvalid, r0_rdata} !== {1'b1, 32'd2, 1'b0, 32'd0}) begin
            tests_failed++;
            $display("FAIL sub_result: rvalid1=%b rdata1=%0d rvalid0=%b rdata0=%0d expected 1 2 0 0",
                     r1_rvalid, r1_rdata, r0_rvalid, r0_rdata);
        end
        r1_rready = 1'b1; tick(); r1_rready = 1'b0;
        r1_op = 6'b010101; r1_rv1 = 32'h8000_0000; r1_rv2 = 32'd4; r1_valid = 1'b1;
        tick(); r1_valid = 1'b0;
        tick(); tick();
        tests_run++;
        if ({r1_rvalid, r1_rdata} !== {1'b1, 32'hF800_0000}) begin
            tests_failed++;
            $display("FAIL sra_result: rvalid1=%b rdata1=%h expected 1 f8000000", r1_rvalid, r1_rdata);
        end
        r1_rready = 1'b1; tick(); r1_rready = 1'b0;
    endtask

    task automatic test_round_robin;
        r0_op = 6'b000000; r0_rv1 = 32'd10; r0_rv2 = 32'd1;
        r1_op = 6'b000000; r1_rv1 = 32'd20; r1_rv2 = 32'd2;
        r0_rready = 1'b1; r1_rready = 1'b1;
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic exp_id;
            exp_id = i[0];
            tests_run++;
            if ({r0_ready, r1_ready} !== (exp_id ? 2'b01 : 2'b10)) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: ready0/ready1=%b expected %s", i,
                         {r0_ready, r1_ready}, exp_id ? "01" : "10");
            end
            tick(); tick(); tick();
            tests_run++;
            if (exp_id ? ({r1_rvalid, r1_rdata, r0_rvalid} !== {1'b1, 32'd22, 1'b0})
                       : ({r0_rvalid, r0_rdata, r1_rvalid} !== {1'b1, 32'd11, 1'b0})) begin
                tests_failed++;
                $display("FAIL rr_result%0d: rvalid0=%b rdata0=%0d rvalid1=%b rdata1=%0d expected owner r%0d data %0d",
                         i, r0_rvalid, r0_rdata, r1_rvalid, r1_rdata, exp_id, exp_id ? 22 : 11);
            end
            tick();
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_rready = 1'b0; r1_rready = 1'b0;
    endtask

    task automatic test_backpressure;
        r0_op = 6'b000000; r0_rv1 = 32'd7; r0_rv2 = 32'd8; r0_valid = 1'b1;
        tick(); r0_valid = 1'b0;
        tick(); tick();
        r1_op = 6'b000000; r1_rv1 = 32'd1; r1_rv2 = 32'd1; r1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({r0_rvalid, r0_rdata, r1_ready, busy, alu_rv2} !== {1'b1, 32'd15, 1'b0, 1'b1, 32'd8}) begin
                tests_failed++;
                $display("FAIL hold%0d: rvalid0=%b rdata0=%0d ready1=%b busy=%b alu_rv2=%0d expected 1 15 0 1 8",
                         i, r0_rvalid, r0_rdata, r1_ready, busy, alu_rv2);
            end
            tick();
        end
        r0_rready = 1'b1; tick(); r0_rready = 1'b0;
        tests_run++;
        if ({r0_rvalid, r1_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL hold_release: rvalid0=%b ready1=%b expected 0 1", r0_rvalid, r1_ready);
        end
        tick(); r1_valid = 1'b0;
        tick(); tick();
        tests_run++;
        if ({r1_rvalid, r1_rdata} !== {1'b1, 32'd2}) begin
            tests_failed++;
            $display("FAIL hold_next: rvalid1=%b rdata1=%0d expected 1 2", r1_rvalid, r1_rdata);
        end
        r1_rready = 1'b1; tick(); r1_rready = 1'b0;
    endtask

    task automatic test_reset_mid;
        // r0 completes first so the pointer favours r1 before reset.
        r0_op = 6'b000000; r0_rv1 = 32'd100; r0_rv2 = 32'd23; r0_valid = 1'b1;
        tick(); r0_valid = 1'b0;
        tick(); tick();
        tests_run++;
        if (r0_rdata !== 32'd123) begin
            tests_failed++;
            $display("FAIL pre_reset_op: rdata0=%0d expected 123", r0_rdata);
        end
        r0_rready = 1'b1; tick(); r0_rready = 1'b0;
        r1_op = 6'b000000; r1_rv1 = 32'd4; r1_rv2 = 32'd4; r1_valid = 1'b1;
        tick(); r1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, r1_rvalid, alu_rv1, alu_rv2} !== 66'd0) begin
            tests_failed++;
            $display("FAIL async_reset: busy=%b rvalid1=%b alu_rv1=%0d alu_rv2=%0d expected all 0",
                     busy, r1_rvalid, alu_rv1, alu_rv2);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({r0_rvalid, r1_rvalid, busy} !== 3'b000) begin
                tests_failed++;
                $display("FAIL discard%0d: rvalid0/rvalid1/busy=%b expected 000", i,
                         {r0_rvalid, r1_rvalid, busy});
            end
        end
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        tests_run++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_ptr: ready0/ready1=%b expected 10", {r0_ready, r1_ready});
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        tick();
    endtask

    task automatic test_settle1;
        s_r0_op = 6'b011000; s_r0_rv1 = 32'd100; s_r0_rv2 = 32'd1; s_r0_valid = 1'b1;
        #1;
        tests_run++;
        if (s_r0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL s1_grant: ready0=%b expected 1", s_r0_ready);
        end
        tick(); s_r0_valid = 1'b0;
        tests_run++;
        if ({s_r0_rvalid, s_busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL s1_wait: rvalid0=%b busy=%b expected 0 1", s_r0_rvalid, s_busy);
        end
        tick();
        tests_run++;
        if ({s_r0_rvalid, s_r0_rdata, s_r1_rvalid} !== {1'b1, 32'd99, 1'b0}) begin
            tests_failed++;
            $display("FAIL s1_result: rvalid0=%b rdata0=%0d rvalid1=%b expected 1 99 0",
                     s_r0_rvalid, s_r0_rdata, s_r1_rvalid);
        end
        s_r0_rready = 1'b1; tick(); s_r0_rready = 1'b0;
        tests_run++;
        if ({s_r0_rvalid, s_busy, s_r1_ready, s_r1_rdata} !== 35'd0) begin
            tests_failed++;
            $display("FAIL s1_release: rvalid0=%b busy=%b ready1=%b rdata1=%0d expected 0 0 0 0",
                     s_r0_rvalid, s_busy, s_r1_ready, s_r1_rdata);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        r0_valid = 1'b0; r0_rready = 1'b0; r0_op = '0; r0_rv1 = '0; r0_rv2 = '0;
        r1_valid = 1'b0; r1_rready = 1'b0; r1_op = '0; r1_rv1 = '0; r1_rv2 = '0;
        s_r0_valid = 1'b0; s_r0_rready = 1'b0; s_r0_op = '0; s_r0_rv1 = '0; s_r0_rv2 = '0;
        test_reset();
        test_add();
        test_sub_sra();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_settle1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
